miller_decoder: RTL
===================

Name: miller_decoder

Overview:
- Receive-side counterpart of the team's Miller (delay-modulation) line encoder.
- Oversamples the raw RF line and measures intervals between transitions to recover the NRZ bit stream.
- Output is a bit stream with a one-cycle valid strobe, plus lock, error and frame-end status.
- Sits between the RF front-end comparator output and the frame/byte assembler.

Parameters:
HALF_CYCLES, 8, clk cycles per half-bit period (minimum 4)
TOL, 2, allowed ± deviation in cycles per interval classification (must be < HALF_CYCLES/2)
SYNC_LEN, 4, consecutive 2-half-bit intervals required before start-bit search
CNT_W, 8, interval counter width; must hold 4*HALF_CYCLES+TOL+1

Ports:
clk  in  1  oversampling clock
rst  in  1  asynchronous, active-high reset
enable  in  1  decoder enable; low forces HUNT
rf_in  in  1  raw Miller line, asynchronous to clk
dout  out  1  decoded bit, meaningful only while dout_valid=1
dout_valid  out  1  one-cycle strobe per decoded bit
locked  out  1  high while in LOCK_MID or LOCK_BND
err  out  1  one-cycle pulse on an illegal interval while locked
frame_end  out  1  one-cycle pulse on an edge timeout while locked

Behaviour:
- Reset (async, rst=1): all outputs 0, state HUNT, sync count 0, interval counter 0, synchronizer flops 0.
- rf_in passes through a 2-flop synchronizer, then a registered edge detector (any polarity).
- Interval counter: clears on each detected edge, otherwise increments and saturates at all-ones.
- On an edge, the elapsed count c is classified as n half-bits (n=2,3,4) if |c − n*HALF_CYCLES| ≤ TOL; any other c is class ILLEGAL.
- Line code, with half-bit = one encoder clk2x cycle:
  - Bit 1: transition at mid-bit.
  - Bit 0: no mid-bit transition; transition at bit start only if the previous bit was also 0.
- States:
  - HUNT:
    - n=2 increments the sync count (saturating).
    - n=3 with sync count ≥ SYNC_LEN → LOCK_MID; this is the start-bit '1', which is not output.
    - n=3 below SYNC_LEN, n=4, or ILLEGAL → sync count cleared.
  - LOCK_MID (last edge at mid-bit):
    - n=2 → emit 1; stay.
    - n=3 → emit 0,0; go to LOCK_BND.
    - n=4 → emit 0,1; stay.
  - LOCK_BND (last edge at bit boundary; that bit was already emitted as 0):
    - n=2 → emit 0; stay.
    - n=3 → emit 1; go to LOCK_MID.
    - n=4 → illegal.
  - Any illegal interval while locked: err pulse, no bits emitted, go to HUNT, sync count cleared.
  - Timeout while locked: counter reaches 4*HALF_CYCLES+TOL+1 with no edge → frame_end pulse, go to HUNT. Trailing undetermined bits are discarded.
- Emission timing:
  - First bit: dout/dout_valid registered, asserted 4 clk after the rf_in change is sampled (2 sync + 1 edge + 1 decode).
  - Second bit of a pair: on the immediately following cycle.
  - dout_valid is never high for more than 2 consecutive cycles.
- enable=0: synchronous return to HUNT; outputs held 0; counter keeps running. An in-progress pair completes its second bit only if enable stays high.
- Edge arriving in the same cycle as the timeout threshold: the edge wins (classified normally).
- HUNT gives no valid, err or frame_end pulses.
- The link protocol guarantees a preamble of ≥SYNC_LEN+1 zeros then a '1' start bit. Lock on other patterns is not guaranteed correct.

Test Plan:
- HALF_CYCLES=8: ideal encoder waveform of 8 zeros, start 1, data 1,0,1,1,0,0, then idle → locked rises at start-bit edge; dout sequence 1,0,1,1,0,0 (pairs on consecutive cycles); frame_end one pulse ~34 clk after last edge; locked falls.
- Same frame, edges jittered ±2 cycles → identical bits; ±3 jitter on one data interval → err pulse, locked=0, no further valid until re-sync.
- Locked in LOCK_BND, inject 32-cycle interval → err, HUNT; subsequent clean preamble + start bit → relock, correct data.
- Preamble of only 3 zeros (SYNC_LEN=4) then start bit → no lock, no dout_valid.
- Assert rst asynchronously mid-frame (between clk edges) → all outputs 0 immediately; no valid until a fresh preamble.
- Drop enable for 1 cycle mid-frame → outputs 0, locked=0; remainder of frame ignored until next preamble.

Source files
------------

// File: rtl/miller_decoder.sv
// Miller (delay-modulation) line decoder.
// Oversamples the raw line, times the intervals between transitions and
// turns them into an NRZ bit stream with a one-cycle valid strobe, plus
// lock, illegal-interval and end-of-frame status.
module miller_decoder #(
  parameter int HALF_CYCLES = 8,  // clk cycles per half-bit period
  parameter int TOL         = 2,  // +/- cycles accepted per interval class
  parameter int SYNC_LEN    = 4,  // 2-half-bit intervals needed before lock
  parameter int CNT_W       = 8   // interval counter width
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic rf_in,
  output logic dout,
  output logic dout_valid,
  output logic locked,
  output logic err,
  output logic frame_end
);

  localparam int E_W     = CNT_W + 1;
  localparam int SYNC_W  = $clog2(SYNC_LEN + 1);
  localparam int TIMEOUT = 4 * HALF_CYCLES + TOL + 1;

  // Interval window bounds, in elapsed cycles.
  localparam logic [E_W-1:0] LO2 = E_W'(2 * HALF_CYCLES - TOL);
  localparam logic [E_W-1:0] HI2 = E_W'(2 * HALF_CYCLES + TOL);
  localparam logic [E_W-1:0] LO3 = E_W'(3 * HALF_CYCLES - TOL);
  localparam logic [E_W-1:0] HI3 = E_W'(3 * HALF_CYCLES + TOL);
  localparam logic [E_W-1:0] LO4 = E_W'(4 * HALF_CYCLES - TOL);
  localparam logic [E_W-1:0] HI4 = E_W'(4 * HALF_CYCLES + TOL);
  localparam logic [E_W-1:0] TIMEOUT_E = E_W'(TIMEOUT);
  localparam logic [SYNC_W-1:0] SYNC_MAX = SYNC_W'(SYNC_LEN);

  typedef enum logic [1:0] {
    S_HUNT,
    S_LOCK_MID,  // last edge was at mid-bit
    S_LOCK_BND   // last edge was at a bit boundary (that bit already emitted)
  } state_t;

  typedef enum logic [1:0] {
    C_ILLEGAL,
    C_TWO,
    C_THREE,
    C_FOUR
  } iclass_t;

  // Front end: synchronizer, edge detector, interval counter.
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  logic             edge_q, edge_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Decoder state and registered outputs.
  state_t            state_q, state_d;
  logic [SYNC_W-1:0] sync_cnt_q, sync_cnt_d;
  logic              pend_q, pend_d;          // second bit of a pair waiting
  logic              pend_bit_q, pend_bit_d;
  logic              dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              err_q, err_d;
  logic              frame_end_q, frame_end_d;

  logic [E_W-1:0] elapsed;
  iclass_t        iclass;

  function automatic iclass_t classify(input logic [E_W-1:0] c);
    if (c >= LO2 && c <= HI2)      return C_TWO;
    else if (c >= LO3 && c <= HI3) return C_THREE;
    else if (c >= LO4 && c <= HI4) return C_FOUR;
    else                           return C_ILLEGAL;
  endfunction

  // Elapsed cycles since the previous edge, counting the current edge cycle.
  assign elapsed = {1'b0, cnt_q} + E_W'(1);
  assign iclass  = classify(elapsed);

  // Front-end next-state: sync chain, any-polarity edge, saturating counter.
  always_comb begin
    sync1_d = rf_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    edge_d  = sync2_q ^ prev_q;
    if (edge_q)           cnt_d = '0;
    else if (cnt_q == '1) cnt_d = cnt_q;
    else                  cnt_d = cnt_q + CNT_W'(1);
  end

  // Decoder next-state and output computation.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    sync_cnt_d   = sync_cnt_q;
    pend_d       = 1'b0;
    pend_bit_d   = pend_bit_q;
    dout_d       = 1'b0;
    dout_valid_d = 1'b0;
    err_d        = 1'b0;
    frame_end_d  = 1'b0;

    if (!enable) begin
      state_d    = S_HUNT;
      sync_cnt_d = '0;
    end else begin
      if (pend_q) begin
        dout_valid_d = 1'b1;
        dout_d       = pend_bit_q;
      end

      unique case (state_q)
        S_HUNT: begin
          if (edge_q) begin
            unique case (iclass)
              C_TWO:   if (sync_cnt_q != SYNC_MAX) sync_cnt_d = sync_cnt_q + SYNC_W'(1);
              C_THREE: begin
                // The 3-half-bit interval after the preamble is the start bit.
                if (sync_cnt_q >= SYNC_MAX) state_d = S_LOCK_MID;
                sync_cnt_d = '0;
              end
              default: sync_cnt_d = '0;
            endcase
          end
        end

        S_LOCK_MID: begin
          if (edge_q) begin
            unique case (iclass)
              C_TWO: begin
                dout_valid_d = 1'b1;
                dout_d       = 1'b1;
              end
              C_THREE: begin
                dout_valid_d = 1'b1;
                dout_d       = 1'b0;
                pend_d       = 1'b1;
                pend_bit_d   = 1'b0;
                state_d      = S_LOCK_BND;
              end
              C_FOUR: begin
                dout_valid_d = 1'b1;
                dout_d       = 1'b0;
                pend_d       = 1'b1;
                pend_bit_d   = 1'b1;
              end
              default: begin
                err_d      = 1'b1;
                state_d    = S_HUNT;
                sync_cnt_d = '0;
              end
            endcase
          end else if (elapsed == TIMEOUT_E) begin
            frame_end_d = 1'b1;
            state_d     = S_HUNT;
            sync_cnt_d  = '0;
          end
        end

        S_LOCK_BND: begin
          if (edge_q) begin
            unique case (iclass)
              C_TWO: begin
                dout_valid_d = 1'b1;
                dout_d       = 1'b0;
              end
              C_THREE: begin
                dout_valid_d = 1'b1;
                dout_d       = 1'b1;
                state_d      = S_LOCK_MID;
              end
              default: begin
                err_d      = 1'b1;
                state_d    = S_HUNT;
                sync_cnt_d = '0;
              end
            endcase
          end else if (elapsed == TIMEOUT_E) begin
            frame_end_d = 1'b1;
            state_d     = S_HUNT;
            sync_cnt_d  = '0;
          end
        end

        default: begin
          state_d    = S_HUNT;
          sync_cnt_d = '0;
        end
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      prev_q       <= 1'b0;
      edge_q       <= 1'b0;
      cnt_q        <= '0;
      state_q      <= S_HUNT;
      sync_cnt_q   <= '0;
      pend_q       <= 1'b0;
      pend_bit_q   <= 1'b0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      err_q        <= 1'b0;
      frame_end_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      prev_q       <= prev_d;
      edge_q       <= edge_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      sync_cnt_q   <= sync_cnt_d;
      pend_q       <= pend_d;
      pend_bit_q   <= pend_bit_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      err_q        <= err_d;
      frame_end_q  <= frame_end_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign err        = err_q;
  assign frame_end  = frame_end_q;
  assign locked     = (state_q != S_HUNT);

endmodule
